// File: rtl/adt_pkg.sv
// ============================================================================
// Module      : adt_pkg
// Description : Shared constants and FSM encoding for the ADT serial link
//               frame transmit and receive paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adt_pkg;

    // Frame header bytes, sent first on every frame
    localparam logic [7:0] SOF_L         = 8'h64;
    localparam logic [7:0] SOF_H         = 8'h00;

    // Total bytes per frame (header + payload + checksum) and payload size
    localparam int         R_FRAME_LEN   = 25;
    localparam int         PAYLOAD_BYTES = 22;

    // Idle clk cycles between byte_done and the next byte_start
    localparam int         T_GAP         = 5;

    // Transmit FSM encoding
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_GAP  = 4'd1,
        ST_SEND = 4'd2,
        ST_DONE = 4'd3
    } adt_tx_state_e;

endpackage

`default_nettype wire

// File: rtl/adt_frame_tx.sv
// ============================================================================
// Module      : adt_frame_tx
// Description : ADT response frame transmitter. Sends SOF_L, SOF_H, 22
//               payload bytes and an 8-bit additive checksum to a byte UART
//               over a byte_start/byte_done handshake.
//               Optional macro ADT_TX_TIMEOUT_EN adds a byte_done watchdog
//               (T_DONE_TO clk cycles) that aborts the frame with tx_error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adt_frame_tx #(
    parameter logic [31:0] T_DONE_TO = 32'd50_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         frame_start,
    input  logic [175:0] payload,
    input  logic         byte_done,
    output logic [7:0]   byte_data,
    output logic         byte_start,
    output logic         tx_busy,
    output logic         frame_done,
    output logic         tx_error
);

    import adt_pkg::*;

    localparam logic [4:0] C_LAST_IDX = 5'(R_FRAME_LEN - 1);
    localparam logic [7:0] C_GAP_LAST = 8'(T_GAP - 1);

    adt_tx_state_e                  r_state,      w_state_nxt;
    logic [PAYLOAD_BYTES-1:0][7:0]  r_shadow,     w_shadow_nxt;
    logic [4:0]                     r_byte_cnt,   w_byte_cnt_nxt;
    logic [7:0]                     r_csum,       w_csum_nxt;
    logic [7:0]                     r_gap_cnt,    w_gap_cnt_nxt;
    logic [7:0]                     r_byte_data,  w_byte_data_nxt;
    logic                           r_byte_start, w_byte_start_nxt;
    logic                           r_tx_busy,    w_tx_busy_nxt;
    logic                           r_frame_done, w_frame_done_nxt;
    logic [4:0]                     w_pl_idx;
    logic [7:0]                     w_mux_byte;
`ifdef ADT_TX_TIMEOUT_EN
    logic [31:0]                    r_to_cnt,     w_to_cnt_nxt;
    logic                           r_tx_error,   w_tx_error_nxt;
`endif

    // Select the byte to present for the current byte_cnt
    always_comb begin
        w_pl_idx   = 5'd0;
        w_mux_byte = r_shadow[0];
        if (r_byte_cnt == 5'd0) begin
            w_mux_byte = SOF_L;
        end else if (r_byte_cnt == 5'd1) begin
            w_mux_byte = SOF_H;
        end else if (r_byte_cnt == C_LAST_IDX) begin
            w_mux_byte = r_csum;
        end else begin
            w_pl_idx   = r_byte_cnt - 5'd2;
            w_mux_byte = r_shadow[w_pl_idx];
        end
    end

    // Next-state and next-value logic for the FSM and its datapath
    always_comb begin
        w_state_nxt      = r_state;
        w_shadow_nxt     = r_shadow;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_csum_nxt       = r_csum;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_byte_data_nxt  = r_byte_data;
        w_byte_start_nxt = r_byte_start;
        w_tx_busy_nxt    = r_tx_busy;
        w_frame_done_nxt = 1'b0;
`ifdef ADT_TX_TIMEOUT_EN
        w_to_cnt_nxt     = r_to_cnt;
        w_tx_error_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // byte_done is ignored here; only frame_start matters
                if (frame_start) begin
                    w_shadow_nxt   = payload;
                    w_byte_cnt_nxt = 5'd0;
                    w_csum_nxt     = 8'd0;
                    w_gap_cnt_nxt  = 8'd0;
                    w_tx_busy_nxt  = 1'b1;
                    w_state_nxt    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == C_GAP_LAST) begin
                    w_gap_cnt_nxt    = 8'd0;
                    w_byte_start_nxt = 1'b1;
                    w_byte_data_nxt  = w_mux_byte;
                    w_state_nxt      = ST_SEND;
`ifdef ADT_TX_TIMEOUT_EN
                    w_to_cnt_nxt     = 32'd0;
`endif
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end
            ST_SEND: begin
`ifdef ADT_TX_TIMEOUT_EN
                w_to_cnt_nxt = r_to_cnt + 32'd1;
`endif
                if (byte_done) begin
                    w_byte_start_nxt = 1'b0;
`ifdef ADT_TX_TIMEOUT_EN
                    w_to_cnt_nxt     = 32'd0;
`endif
                    if (r_byte_cnt < C_LAST_IDX) begin
                        w_csum_nxt     = r_csum + r_byte_data;
                        w_byte_cnt_nxt = r_byte_cnt + 5'd1;
                    end
                    if (r_byte_cnt == C_LAST_IDX) begin
                        w_frame_done_nxt = 1'b1;
                        w_tx_busy_nxt    = 1'b0;
                        w_state_nxt      = ST_DONE;
                    end else begin
                        w_gap_cnt_nxt = 8'd0;
                        w_state_nxt   = ST_GAP;
                    end
                end
`ifdef ADT_TX_TIMEOUT_EN
                // Timeout lands the error pulse T_DONE_TO cycles after byte_start rose
                else if (r_to_cnt == T_DONE_TO - 32'd1) begin
                    w_byte_start_nxt = 1'b0;
                    w_tx_busy_nxt    = 1'b0;
                    w_tx_error_nxt   = 1'b1;
                    w_to_cnt_nxt     = 32'd0;
                    w_state_nxt      = ST_IDLE;
                end
`endif
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_shadow     <= '0;
            r_byte_cnt   <= 5'd0;
            r_csum       <= 8'd0;
            r_gap_cnt    <= 8'd0;
            r_byte_data  <= 8'd0;
            r_byte_start <= 1'b0;
            r_tx_busy    <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef ADT_TX_TIMEOUT_EN
            r_to_cnt     <= 32'd0;
            r_tx_error   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_shadow     <= w_shadow_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_csum       <= w_csum_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_byte_data  <= w_byte_data_nxt;
            r_byte_start <= w_byte_start_nxt;
            r_tx_busy    <= w_tx_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
`ifdef ADT_TX_TIMEOUT_EN
            r_to_cnt     <= w_to_cnt_nxt;
            r_tx_error   <= w_tx_error_nxt;
`endif
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_start = r_byte_start;
    assign tx_busy    = r_tx_busy;
    assign frame_done = r_frame_done;
`ifdef ADT_TX_TIMEOUT_EN
    assign tx_error   = r_tx_error;
`else
    assign tx_error   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adt_frame_tx.sv
// ============================================================================
// Module      : tb_adt_frame_tx
// Description : Directed self-checking bench for adt_frame_tx. Acts as the
//               UART side of the handshake and checks every frame byte,
//               inter-byte gap timing, busy rejection, reset and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adt_frame_tx;

    import adt_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         frame_start = 1'b0;
    logic [175:0] payload = '0;
    logic         byte_done = 1'b0;
    logic [7:0]   byte_data;
    logic         byte_start;
    logic         tx_busy;
    logic         frame_done;
    logic         tx_error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fd_seen  = 0;
    int err_seen = 0;

    logic [175:0] r_count_pl;
    logic [175:0] r_ff_pl;

    adt_frame_tx #(.T_DONE_TO(32'd100)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .payload     (payload),
        .byte_done   (byte_done),
        .byte_data   (byte_data),
        .byte_start  (byte_start),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done),
        .tx_error    (tx_error)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time rises relative to handshake events
    always @(posedge clk) cyc <= cyc + 1;

    // Count every cycle with frame_done or tx_error high
    always @(negedge clk) begin
        if (frame_done) fd_seen  <= fd_seen + 1;
        if (tx_error)   err_seen <= err_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one frame acting as the UART; dly = cycles byte_done is withheld,
    // inject_at = byte index where a competing frame_start is pulsed,
    // reset_at = byte index where reset is asserted mid-frame.
    task automatic run_frame(input string name, input logic [175:0] pl, input logic [7:0] exp_csum,
                             input int dly, input int inject_at, input int reset_at, input bit stray);
        logic [7:0] exp_b [25];
        logic [7:0] held;
        int anchor;
        int rises;
        int fd0;
        int waited;
        exp_b[0] = 8'h64;
        exp_b[1] = 8'h00;
        for (int k = 2; k < 24; k++) exp_b[k] = pl[8*(k-2) +: 8];
        exp_b[24] = exp_csum;
        fd0   = fd_seen;
        rises = 0;
        payload     = pl;
        frame_start = 1'b1;
        byte_done   = stray;
        anchor      = cyc;
        step();
        frame_start = 1'b0;
        byte_done   = 1'b0;
        payload     = ~pl;
        check({name, ":busy"}, 32'(tx_busy), 32'd1);
        for (int b = 0; b < 25; b++) begin
            waited = 0;
            while (!byte_start && waited < 3000) begin
                step();
                waited++;
            end
            if (!byte_start) begin
                check({name, ":rise_timeout"}, 32'd0, 32'd1);
                return;
            end
            rises++;
            check({name, ":gap"}, 32'(cyc), 32'(anchor + 1 + T_GAP));
            check({name, ":byte"}, 32'(byte_data), 32'(exp_b[b]));
            held = byte_data;
            if (b == reset_at) begin
                reset_n = 1'b0;
                #1;
                check({name, ":reset_outs"},
                      32'({byte_data, byte_start, tx_busy, frame_done, tx_error}), 32'd0);
                step();
                reset_n = 1'b1;
                step();
                check({name, ":reset_idle"}, 32'({byte_start, tx_busy}), 32'd0);
                return;
            end
            if (b == inject_at) begin
                payload     = pl ^ {22{8'h5A}};
                frame_start = 1'b1;
                step();
                frame_start = 1'b0;
            end
            for (int d = 0; d < dly; d++) step();
            check({name, ":hold"}, 32'({byte_start, byte_data}), 32'({1'b1, held}));
            byte_done = 1'b1;
            anchor    = cyc;
            step();
            byte_done = 1'b0;
            if (b < 24) check({name, ":drop"}, 32'(byte_start), 32'd0);
        end
        check({name, ":done"}, 32'({frame_done, tx_busy, byte_start}), 32'b100);
        check({name, ":rises"}, 32'(rises), 32'd25);
        step();
        check({name, ":done_pulse"}, 32'(frame_done), 32'd0);
        check({name, ":done_cnt"}, 32'(fd_seen - fd0), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 22; i++) begin
            r_count_pl[8*i +: 8] = 8'(i + 1);
            r_ff_pl[8*i +: 8]    = 8'hFF;
        end

        // Reset state
        step();
        check("reset_outs", 32'({byte_data, byte_start, tx_busy, frame_done, tx_error}), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Stray byte_done in IDLE must not affect anything
        byte_done = 1'b1;
        step();
        byte_done = 1'b0;
        check("idle_stray", 32'({byte_start, tx_busy}), 32'd0);

        // Zero payload, with a stray byte_done alongside frame_start
        run_frame("zero", '0, 8'h64, 0, -1, -1, 1'b1);
        // Counting payload, byte_done one cycle late
        run_frame("count", r_count_pl, 8'h61, 1, -1, -1, 1'b0);
        // All-0xFF payload with a rejected frame_start at byte 10
        run_frame("wrap_busy", r_ff_pl, 8'h4E, 0, 10, -1, 1'b0);
        // Re-arm directly after frame_done; byte_done withheld 1000 cycles
        run_frame("rearm_slow", r_count_pl, 8'h61, 1000, -1, -1, 1'b0);
        // Reset at byte 7, then a clean frame from SOF_L
        run_frame("mid_reset", r_ff_pl, 8'h4E, 0, -1, 7, 1'b0);
        run_frame("after_reset", r_count_pl, 8'h61, 0, -1, -1, 1'b0);

`ifdef ADT_TX_TIMEOUT_EN
        begin
            int r;
            int waited;
            int fd0;
            fd0         = fd_seen;
            payload     = r_count_pl;
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            waited = 0;
            while (!byte_start && waited < 100) begin
                step();
                waited++;
            end
            r = cyc;
            waited = 0;
            while (!tx_error && waited < 300) begin
                step();
                waited++;
            end
            check("to_cycle", 32'(cyc), 32'(r + 100));
            check("to_outs", 32'({tx_error, tx_busy, byte_start}), 32'b100);
            step();
            check("to_pulse", 32'(tx_error), 32'd0);
            check("to_no_done", 32'(fd_seen - fd0), 32'd0);
        end
        run_frame("after_to", r_ff_pl, 8'h4E, 0, -1, -1, 1'b0);
`else
        check("no_error", 32'(err_seen), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adt_frame_tx.md
# adt_frame_tx

Frame transmitter for the ADT serial link. Sends the 25-byte response frame that the terminal's receiver parses:
- SOF_L, SOF_H, 22 payload bytes, then an 8-bit additive checksum.

It sits between a frame producer, which supplies a 176-bit payload and a start pulse, and the existing byte UART pair (`speed_select` + `my_uart_tx`) in the parent. It drives that UART through the byte_start/byte_done handshake.

## Interface
- SOF_L, 8'h64, frame byte 0
- SOF_H, 8'h00, frame byte 1
- FRAME_LEN, 8'd25, total bytes per frame including checksum
- T_GAP, 5, idle clk cycles between byte_done and the next byte_start
- T_DONE_TO, 32'd50_000_000, byte_done watchdog in clk cycles (only with ADT_TX_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle request to send a frame
- payload  in  176  frame byte k (k=2..23) = payload[8(k-2)+7 : 8(k-2)]; sampled only on an accepted frame_start
- byte_done  in  1  one-cycle pulse from the UART: current byte finished
- byte_data  out  8  byte for the UART; valid whenever byte_start=1
- byte_start  out  1  level request to the UART; held high until byte_done
- tx_busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last byte completes
- tx_error  out  1  one-cycle pulse on watchdog abort; tied 0 without ADT_TX_TIMEOUT_EN

## Operation
- Reset values: byte_data=0, byte_start=0, tx_busy=0, frame_done=0, tx_error=0. All internal state is cleared and the FSM is in IDLE.

State machine IDLE / GAP / SEND / DONE:
- **IDLE:** frame_start=1 latches payload into a shadow register, clears byte_cnt and csum, sets tx_busy, and moves to GAP.
- **GAP:** gap_cnt counts up from 0. When gap_cnt reaches T_GAP-1, the FSM raises byte_start, drives byte_data, and moves to SEND.
- **SEND:** byte_start and byte_data are held stable. On byte_done:
  - byte_start is cleared.
  - If byte_cnt<24: csum += byte_data and byte_cnt++.
  - If byte_cnt==FRAME_LEN-1 (the checksum byte), the FSM moves to DONE; otherwise it moves to GAP.
- **DONE:** frame_done=1 and tx_busy=0 for one cycle, then IDLE.

Byte mux by byte_cnt:
- 0 → SOF_L
- 1 → SOF_H
- 2..23 → shadow payload bytes
- 24 → csum

Checksum rule:
- csum is an 8-bit wrap-around sum of bytes 0..23.
- The checksum byte itself is not added.

Boundary conditions:
- frame_start while tx_busy=1 is ignored. The payload shadow is unchanged.
- byte_done outside SEND is ignored.
- frame_start and a stray byte_done in the same IDLE cycle: the frame starts and the byte_done is ignored.
- The payload input may change freely after frame_start is accepted.
- Reset mid-frame returns every output to its reset value within the reset assertion. No partial resume.

## Timing
- frame_start at cycle 0 → tx_busy=1 at cycle 1 → byte_start=1 at cycle 1+T_GAP.
- byte_done at cycle t → byte_start=0 at t+1 → next byte_start=1 at t+1+T_GAP.
- 25th byte_done at t → frame_done=1 and tx_busy=0 at t+1. A new frame_start is accepted from t+2.
- byte_data changes only in the cycle byte_start rises.
- Frame length = 25×(T_GAP + UART byte time + 1) + 2 cycles.

## Configuration
- **ADT_TX_TIMEOUT_EN defined:**
  - A 32-bit counter runs in SEND and clears on byte_done.
  - When the counter reaches T_DONE_TO, the frame is aborted: byte_start=0, tx_busy=0, tx_error=1 for one cycle, FSM to IDLE, frame_done not asserted.
- **Not defined:**
  - No counter is present and tx_error is constant 0.
  - SEND waits indefinitely for byte_done.

## Structure
- Shared package `adt_pkg` holds:
  - SOF_L, SOF_H, R_FRAME_LEN=25, PAYLOAD_BYTES=22
  - the FSM state encoding (4-bit localparams)
- These constants are shared with the terminal receive path.
- No sub-module: the shadow register, mux, checksum and FSM stay flat.
- The UART (`speed_select` + `my_uart_tx`) is instantiated by the parent, not inside this block.

## Test plan
- **Zero payload:** payload=0, frame_start → 64 00, then 22×00, then checksum 64. Exactly one frame_done and 25 byte_start rises.
- **Counting payload:** payload bytes 0x01..0x16 → checksum 0x61. Bytes appear in order on byte_data.
- **Wrap-around:** payload all 0xFF → checksum 0x4E.
- **Busy rejection and re-arm:** frame_start repeated at byte 10 with a different payload → ignored, original bytes sent. frame_start at frame_done+1 → accepted.
- **Gap and handshake:** bench delays byte_done by 1 and by 1000 cycles → byte_data and byte_start stable across the delay; next byte_start exactly T_GAP+1 cycles after byte_done.
- **Reset mid-frame and timeout:** reset_n low at byte 7 → all outputs 0, next frame starts from SOF_L. With ADT_TX_TIMEOUT_EN and T_DONE_TO=100, withhold byte_done → tx_error pulse 100 cycles after byte_start, tx_busy=0, no frame_done.
